// File: rtl/word_byte_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : word_byte_serializer_pkg                                  |
// | Brief    : Shared types, constants and lane-select helper.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package word_byte_serializer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Bit offset of byte k; byte 0 is the top lane unless lsb_first is set.
  function automatic int unsigned lane_offset(input int unsigned idx,
                                              input logic        lsb_first,
                                              input int unsigned nbytes);
    if (lsb_first) begin
      return BYTE_W * idx;
    end
    return BYTE_W * (nbytes - 1 - idx);
  endfunction

endpackage : word_byte_serializer_pkg
`default_nettype wire

// File: rtl/word_byte_serializer_byte_lane_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : byte_lane_mux                                             |
// | Brief    : Combinational selector returning byte k of a word.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module byte_lane_mux
  import word_byte_serializer_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NBYTES*BYTE_W-1:0] word,
  input  logic [IDX_W-1:0]         idx,
  input  logic                     lsb_first,
  output logic [BYTE_W-1:0]        lane_byte
);

  logic [NBYTES*BYTE_W-1:0] shifted;

  always_comb begin
    shifted   = word >> lane_offset(32'(idx), lsb_first, NBYTES);
    lane_byte = shifted[BYTE_W-1:0];
  end

endmodule : byte_lane_mux
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : word_byte_serializer                                      |
// | Brief    : Accepts a word over valid/ready, emits its bytes serially. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module word_byte_serializer
  import word_byte_serializer_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [2:0]        in_nbytes,
  input  logic              in_lsb_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_done
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e             state_q,      state_d;
  logic [WORD_W-1:0]  word_q,       word_d;
  logic               lsb_q,        lsb_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic [IDX_W-1:0]   last_idx_q,   last_idx_d;
  logic [CNT_W-1:0]   words_done_q, words_done_d;

  logic               send;
  logic               load;
  logic               out_fire;
  int unsigned        nb_sat;

  assign send       = (state_q == ST_SEND);
  assign out_valid  = send;
  assign busy       = send;
  assign out_last   = send && (idx_q == last_idx_q);
  assign out_fire   = send && out_ready;
  assign in_ready   = !send || (out_last && out_ready);
  assign load       = in_valid && in_ready;
  assign words_done = words_done_q;

  byte_lane_mux #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_lane_mux (
    .word      (word_q),
    .idx       (idx_q),
    .lsb_first (lsb_q),
    .lane_byte (out_data)
  );

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    lsb_d        = lsb_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    words_done_d = words_done_q;

    // Zero and oversize counts both mean a full word.
    if ((in_nbytes == 3'd0) || (32'(in_nbytes) > NBYTES)) begin
      nb_sat = NBYTES;
    end else begin
      nb_sat = 32'(in_nbytes);
    end

    if (out_fire) begin
      if (out_last) begin
        words_done_d = words_done_q + CNT_W'(1);
        state_d      = ST_IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (load) begin
      state_d    = ST_SEND;
      word_d     = in_data;
      lsb_d      = in_lsb_first;
      idx_d      = '0;
      last_idx_d = IDX_W'(nb_sat - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      lsb_q        <= 1'b0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      lsb_q        <= lsb_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      words_done_q <= words_done_d;
    end
  end

endmodule : word_byte_serializer
`default_nettype wire

// File: tb/tb_word_byte_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_word_byte_serializer                                   |
// | Brief    : Directed self-checking bench for word_byte_serializer.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic        in_lsb_first;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] words_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_wd = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(
    .WORD_W (32),
    .NBYTES (4),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_nbytes    (in_nbytes),
    .in_lsb_first (in_lsb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .words_done   (words_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word for a single cycle, then scrambles the inputs.
  task automatic start_word(input logic [31:0] d, input logic [2:0] nb, input logic lsb);
    in_valid     = 1'b1;
    in_data      = d;
    in_nbytes    = nb;
    in_lsb_first = lsb;
    tick();
    in_valid     = 1'b0;
    in_data      = 32'hFFFF_FFFF;
    in_nbytes    = 3'd1;
    in_lsb_first = ~lsb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_nbytes = '0;
    in_lsb_first = 1'b0; out_ready = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (words_done !== 16'd0) begin n_fail++; $display("FAIL reset_words_done got %0d want 0", words_done); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_basic_msb();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    out_ready = 1'b1;
    start_word(32'h1122_3344, 3'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== exp_b[k]) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", k, out_data, exp_b[k]); end
      n_cmp++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", k, out_last, (k == 3)); end
      n_cmp++; if (in_ready !== (k == 3)) begin n_fail++; $display("FAIL basic_in_ready[%0d] got %b want %b", k, in_ready, (k == 3)); end
      tick();
    end
    exp_wd++;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b want 0", out_valid); end
    n_cmp++; if (words_done !== 16'(exp_wd)) begin n_fail++; $display("FAIL basic_words_done got %0d want %0d", words_done, exp_wd); end
  endtask

  task automatic test_lsb_partial();
    logic [7:0] exp_b [2];
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC;
    out_ready = 1'b1;
    start_word(32'hAABB_CCDD, 3'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid[%0d] got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== exp_b[k]) begin n_fail++; $display("FAIL lsb_data[%0d] got %h want %h", k, out_data, exp_b[k]); end
      n_cmp++; if (out_last !== (k == 1)) begin n_fail++; $display("FAIL lsb_last[%0d] got %b want %b", k, out_last, (k == 1)); end
      tick();
    end
    exp_wd++;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lsb_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lsb_in_ready got %b want 1", in_ready); end
    n_cmp++; if (words_done !== 16'(exp_wd)) begin n_fail++; $display("FAIL lsb_words_done got %0d want %0d", words_done, exp_wd); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [4];
    logic       pat   [7];
    int         k   = 0;
    int         acc = 0;
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h04;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
    out_ready = 1'b0;
    start_word(32'h0102_0304, 3'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      #1;
      if (k < 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
        n_cmp++; if (out_data !== exp_b[k]) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, out_data, exp_b[k]); end
        n_cmp++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL bp_last[%0d] got %b want %b", i, out_last, (k == 3)); end
      end
      if (out_valid === 1'b1 && out_ready) acc++;
      if (out_ready) k++;
      tick();
    end
    exp_wd++;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", acc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", out_valid); end
    n_cmp++; if (words_done !== 16'(exp_wd)) begin n_fail++; $display("FAIL bp_words_done got %0d want %0d", words_done, exp_wd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [8];
    exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hA2; exp_b[3] = 8'hA3;
    exp_b[4] = 8'hB0; exp_b[5] = 8'hB1; exp_b[6] = 8'hB2; exp_b[7] = 8'hB3;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_data      = 32'hA0A1_A2A3;
    in_nbytes    = 3'd4;
    in_lsb_first = 1'b0;
    tick();
    in_data = 32'hB0B1_B2B3;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        in_valid = 1'b0;
        in_data  = 32'h0;
      end
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== exp_b[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, out_data, exp_b[i]); end
      n_cmp++; if (out_last !== (i % 4 == 3)) begin n_fail++; $display("FAIL b2b_last[%0d] got %b want %b", i, out_last, (i % 4 == 3)); end
      tick();
    end
    exp_wd += 2;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", out_valid); end
    n_cmp++; if (words_done !== 16'(exp_wd)) begin n_fail++; $display("FAIL b2b_words_done got %0d want %0d", words_done, exp_wd); end
  endtask

  task automatic test_nbytes();
    logic [7:0] exp_b [4];
    logic [2:0] nbs   [3];
    int         cnt   [3];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    nbs[0] = 3'd0; nbs[1] = 3'd7; nbs[2] = 3'd1;
    cnt[0] = 4;    cnt[1] = 4;    cnt[2] = 1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      start_word(32'hDEAD_BEEF, nbs[c], 1'b0);
      for (int k = 0; k < cnt[c]; k++) begin
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nb%0d_valid[%0d] got %b want 1", nbs[c], k, out_valid); end
        n_cmp++; if (out_data !== exp_b[k]) begin n_fail++; $display("FAIL nb%0d_data[%0d] got %h want %h", nbs[c], k, out_data, exp_b[k]); end
        n_cmp++; if (out_last !== (k == cnt[c] - 1)) begin n_fail++; $display("FAIL nb%0d_last[%0d] got %b want %b", nbs[c], k, out_last, (k == cnt[c] - 1)); end
        tick();
      end
      exp_wd++;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nb%0d_idle got %b want 0", nbs[c], out_valid); end
    end
    n_cmp++; if (words_done !== 16'(exp_wd)) begin n_fail++; $display("FAIL nb_words_done got %0d want %0d", words_done, exp_wd); end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    start_word(32'h5566_7788, 3'd4, 1'b0);
    tick(); tick();
    #1;
    n_cmp++; if (out_data !== 8'h77) begin n_fail++; $display("FAIL rstmid_pre_data got %h want 77", out_data); end
    rst_n = 1'b0;
    #1;
    exp_wd = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (words_done !== 16'(exp_wd)) begin n_fail++; $display("FAIL rstmid_words_done got %0d want 0", words_done); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready[%0d] got %b want 1", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale[%0d] got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_msb();
    test_lsb_partial();
    test_backpressure();
    test_back_to_back();
    test_nbytes();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_word_byte_serializer
`default_nettype wire

// File: doc/word_byte_serializer.md
Name: word_byte_serializer

Overview:
- Sequencer that accepts a 32-bit word over a valid/ready handshake and emits its bytes one per cycle over a second valid/ready handshake.
- Default byte order matches the team's 32-bit byte split: byte 0 = [31:24], byte 1 = [23:16], byte 2 = [15:8], byte 3 = [7:0].
- Sits between a word-wide producer (register file, memory read port) and a byte-wide consumer (UART tx, byte bus).

Parameters:
- WORD_W, 32, input word width; must equal NBYTES*8.
- NBYTES, 4, bytes per word.
- CNT_W, 16, width of the words-completed counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  serializer can accept a word this cycle
- in_data  input  WORD_W  word to serialize
- in_nbytes  input  3  number of bytes to emit, 1..NBYTES; 0 is treated as NBYTES
- in_lsb_first  input  1  1 = emit [7:0] first; 0 = emit [31:24] first
- out_valid  output  1  out_data holds a valid byte
- out_ready  input  1  consumer accepts the byte this cycle
- out_data  output  8  current byte
- out_last  output  1  current byte is the final byte of the word
- busy  output  1  a word is loaded and not fully emitted
- words_done  output  CNT_W  count of fully emitted words, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, synchronous-to-clk deassert handled upstream) sets:
  - state = IDLE
  - out_valid = 0, out_data = 0, out_last = 0
  - busy = 0, words_done = 0
  - internal word register, index and remaining count = 0
- Reset mid-word discards the word; no partial bytes follow the reset.
- States:
  - IDLE: out_valid = 0, in_ready = 1. When in_valid = 1, latch in_data, order and count (0 maps to NBYTES), set index = 0, go to SEND.
  - SEND: out_valid = 1; out_data = selected byte; out_last = (index == count-1).
    - On out_ready with out_last = 0: index increments.
    - On out_ready with out_last = 1: words_done increments, then:
      - in_valid = 1: load the next word, stay in SEND, index = 0.
      - in_valid = 0: go to IDLE.
- Byte select, index k:
  - MSB-first: data[WORD_W-1-8k -: 8].
  - LSB-first: data[8k +: 8].
- Latency: first byte is valid the cycle after the input handshake; a single-byte word finishes in 1 output cycle.
- Throughput: back-to-back words with no bubble when in_valid is held and out_ready is held.
- in_ready = (state == IDLE) | (state == SEND & out_last & out_ready). This is combinational from out_ready and there is no combinational path from in_valid.
- out_data, out_last and out_valid are stable while out_valid = 1 and out_ready = 0. Stall is unlimited.
- in_data, in_nbytes and in_lsb_first are sampled only on the input handshake; later changes are ignored.
- busy = (state == SEND).
- words_done wraps from 0xFFFF to 0 without a flag.
- in_nbytes > NBYTES is saturated to NBYTES.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 1'b0, ST_SEND = 1'b1
  - BYTE_W = 8
  - byte-lane select function (index, lsb_first) -> bit offset
- One natural sub-module: byte_lane_mux. It is combinational and returns byte k of a word for a given order. It is reused by the future byte-to-word packer.
- FSM, index counter and words_done live in the top module.

Test Plan:
- Basic MSB-first: word 0x11223344, nbytes = 4, lsb_first = 0, out_ready held 1 -> bytes 11, 22, 33, 44 on 4 consecutive cycles; out_last only with 44; words_done = 1; in_ready = 1 in the last-byte cycle.
- LSB-first partial: word 0xAABBCCDD, nbytes = 2, lsb_first = 1 -> bytes DD, CC; out_last with CC; then IDLE.
- Backpressure: word 0x01020304, out_ready toggled 1,0,0,1,0,1,1 -> byte order unchanged, out_data held during stalls, exactly 4 accepted bytes.
- Back-to-back: words 0xA0A1A2A3 and 0xB0B1B2B3 with in_valid held and out_ready held 1 -> 8 bytes in 8 cycles, no out_valid gap, words_done = 2.
- nbytes edge cases:
  - nbytes = 0 on 0xDEADBEEF -> 4 bytes.
  - nbytes = 7 -> 4 bytes.
  - nbytes = 1 -> single byte DE with out_last = 1.
- Reset mid-word: assert rst_n = 0 after byte 2 of 0x55667788 -> immediately out_valid = 0, busy = 0, words_done = 0; after release, in_ready = 1 and no stale bytes appear.
